minterm_sweep_checker: RTL and testbench

//  Upstream stimulus and response checker for the 11-input minimized SOP function blocks.
//  - Sweeps all 2^N_IN input vectors into the function under test (FUT).
//  - Samples the FUT output and compares it with a golden truth table loaded beforehand.
//  - Reports mismatch count, first failing minterm, and a pass flag.
//  - Sits between the lab harness (loader/host) and the combinational FUT.

---
 rtl/sweep_pkg.sv | 17 +
 rtl/golden_tbl_ram.sv | 31 +++
 rtl/minterm_sweep_checker.sv | 154 +++++++++++++++
 tb/tb_minterm_sweep_checker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and default sizing for the minterm sweep checker.
package sweep_pkg;

    localparam int unsigned N_IN_DEF   = 11;
    localparam int unsigned ERRW_DEF   = 12;
    localparam int unsigned SETTLE_DEF = 1;

    localparam logic [N_IN_DEF-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/golden_tbl_ram.sv
// Golden truth table: 2^AW x 1 RAM, one write port, one read port, 1-cycle read.
module golden_tbl_ram #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic r_mem [DEPTH];
    logic r_rdata;

    // Contents are deliberately not reset so a loaded table survives rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/minterm_sweep_checker.sv
// Sweeps every input vector into a combinational FUT and compares its output
// against a preloaded golden truth table, reporting mismatch statistics.
module minterm_sweep_checker
    import sweep_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF,
    parameter int unsigned ERRW   = ERRW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tbl_we,
    input  logic [N_IN-1:0] tbl_addr,
    input  logic            tbl_data,
    input  logic            start,
    input  logic            fn_i,
    output logic [N_IN-1:0] vec_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [N_IN-1:0] first_err_addr
);

    localparam int unsigned     SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC    = (N_IN == N_IN_DEF) ? N_IN'(LAST_ADDR) : '1;

    state_e          r_state;
    state_e          w_state_nx;
    logic [N_IN-1:0] r_addr;
    logic [N_IN-1:0] w_addr_nx;
    logic [SW-1:0]   r_settle;
    logic [SW-1:0]   w_settle_nx;
    logic [ERRW-1:0] r_err;
    logic [ERRW-1:0] w_err_nx;
    logic [N_IN-1:0] r_first;
    logic [N_IN-1:0] w_first_nx;
    logic            r_pass;
    logic            w_pass_nx;
    logic            r_busy;
    logic            w_busy_nx;
    logic            r_done;
    logic            w_done_nx;
    logic            w_gold;
    logic            w_tbl_we;
    logic            w_rd_en;

    // Loader writes only land while idle; a sweep must see a frozen table.
    assign w_tbl_we = tbl_we && (r_state == IDLE);
    assign w_rd_en  = (r_state == DRIVE);

    golden_tbl_ram #(
        .AW (N_IN)
    ) u_tbl (
        .clk     (clk),
        .i_we    (w_tbl_we),
        .i_waddr (tbl_addr),
        .i_wdata (tbl_data),
        .i_re    (w_rd_en),
        .i_raddr (r_addr),
        .o_rdata (w_gold)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx  = r_state;
        w_addr_nx   = r_addr;
        w_settle_nx = r_settle;
        w_err_nx    = r_err;
        w_first_nx  = r_first;
        w_pass_nx   = r_pass;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx  = DRIVE;
                    w_addr_nx   = '0;
                    w_settle_nx = '0;
                    w_err_nx    = '0;
                    w_first_nx  = '0;
                    w_pass_nx   = 1'b0;
                    w_busy_nx   = 1'b1;
                end
            end
            DRIVE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_nx = CHECK;
                end else begin
                    w_settle_nx = r_settle + SW'(1);
                end
            end
            CHECK: begin
                if (fn_i != w_gold) begin
                    if (r_err != '1) begin
                        w_err_nx = r_err + ERRW'(1);
                    end
                    if (r_err == '0) begin
                        w_first_nx = r_addr;
                    end
                end
                // The sweep ends at the last minterm rather than wrapping.
                if (r_addr == LAST_VEC) begin
                    w_state_nx = DONE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_pass_nx  = (w_err_nx == '0);
                end else begin
                    w_state_nx  = DRIVE;
                    w_addr_nx   = r_addr + N_IN'(1);
                    w_settle_nx = '0;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_first  <= '0;
            r_pass   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_addr   <= w_addr_nx;
            r_settle <= w_settle_nx;
            r_err    <= w_err_nx;
            r_first  <= w_first_nx;
            r_pass   <= w_pass_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign vec_o          = r_addr;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Scoreboarded bench for minterm_sweep_checker driving a behavioural SOP FUT.
`timescale 1ns/1ps
module tb_minterm_sweep_checker;

    localparam int unsigned N  = 11;
    localparam int unsigned EW = 12;
    localparam int unsigned NV = 1 << N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, tbl_we, tbl_data, start1, start3;
    logic [N-1:0]  tbl_addr;
    logic [N-1:0]  vec1, vec3, first1, first3;
    logic          busy1, done1, pass1, fn1;
    logic          busy3, done3, pass3, fn3;
    logic [EW-1:0] err1, err3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [EW-1:0] err;
        logic [N-1:0]  first;
        logic          pass;
        int            cycles;
        int            vec_bad;
        logic          done_after;
        logic          busy_after;
        logic [EW-1:0] err0;
    } res_t;

    res_t sb_q[$];
    logic gold [NV];

    // Reference FUT: vec[10]=a ... vec[0]=k.
    function automatic logic fut(input logic [N-1:0] v);
        logic a, b, c, d, e, f, g, h, i, j, k;
        {a, b, c, d, e, f, g, h, i, j, k} = v;
        return (a & b & ~c) | (~a & d & e) | (f & ~g & h) | (i & j & k & ~b);
    endfunction

    assign fn1 = fut(vec1);
    assign fn3 = fut(vec3);

    minterm_sweep_checker #(.N_IN(N), .SETTLE(1), .ERRW(EW)) u_dut (
        .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .start(start1), .fn_i(fn1), .vec_o(vec1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .first_err_addr(first1)
    );

    minterm_sweep_checker #(.N_IN(N), .SETTLE(3), .ERRW(EW)) u_dut3 (
        .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .start(start3), .fn_i(fn3), .vec_o(vec3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .first_err_addr(first3)
    );

    // Expected sweep result from the bench's own golden copy versus the FUT model.
    function automatic res_t model_expect(input int cycles);
        res_t r;
        r.err = '0; r.first = '0; r.cycles = cycles; r.vec_bad = 0;
        r.done_after = 1'b0; r.busy_after = 1'b0; r.err0 = '0;
        for (int v = 0; v < NV; v++) begin
            if (gold[v] !== fut(N'(v))) begin
                if (r.err == '0) r.first = N'(v);
                if (r.err != '1) r.err = r.err + EW'(1);
            end
        end
        r.pass = (r.err == '0);
        return r;
    endfunction

    // mode 0: FUT table, 1: bits 5 and 1000 flipped, 2: all ones
    task automatic load_table(input int mode);
        logic b;
        for (int v = 0; v < NV; v++) begin
            b = fut(N'(v));
            if (mode == 1 && (v == 5 || v == 1000)) b = ~b;
            if (mode == 2) b = 1'b1;
            gold[v]  = b;
            tbl_we   = 1'b1;
            tbl_addr = N'(v);
            tbl_data = b;
            @(posedge clk); #1;
        end
        tbl_we = 1'b0;
    endtask

    // Drives a sweep on the SETTLE=1 instance and collects what it reports.
    // poke 1: write gold[0] in the start cycle; poke 2: table write + start mid-sweep.
    task automatic run_sweep(input int poke, output res_t got, output bit to);
        int cnt;
        start1 = 1'b1;
        if (poke == 1) begin
            tbl_we = 1'b1; tbl_addr = '0; tbl_data = gold[0];
        end
        @(posedge clk); #1;
        start1 = 1'b0; tbl_we = 1'b0;
        got.err0 = err1;
        got.vec_bad = 0;
        cnt = 0;
        to = 1'b1;
        if (vec1 !== '0) got.vec_bad++;
        while (cnt < 10000) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt < int'(NV) * 2 && vec1 !== N'(cnt >> 1)) got.vec_bad++;
            if (poke == 2 && cnt == 700) begin
                tbl_we = 1'b1; tbl_addr = N'(1500); tbl_data = ~gold[1500]; start1 = 1'b1;
            end
            if (poke == 2 && cnt == 701) begin
                tbl_we = 1'b0; start1 = 1'b0;
            end
            if (done1) begin
                to = 1'b0;
                break;
            end
        end
        got.cycles = cnt; got.err = err1; got.first = first1; got.pass = pass1;
        @(posedge clk); #1;
        got.done_after = done1;
        got.busy_after = busy1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = 1'b0; start1 = 1'b0; start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        if ({vec1, busy1, done1, pass1, err1, first1} !== '0) begin
            $display("FAIL reset.dut1 got vec=%0d busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
                     vec1, busy1, done1, pass1, err1, first1);
            n_bad++;
        end
        n_cmp++;
        if ({vec3, busy3, done3, pass3, err3, first3} !== '0) begin
            $display("FAIL reset.dut3 got vec=%0d busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
                     vec3, busy3, done3, pass3, err3, first3);
            n_bad++;
        end
        n_cmp++;
    endtask

    // Generic per-test comparison of a collected result against the popped expectation.
    task automatic test_sweep(input string nm, input int mode, input int poke);
        res_t got, exp;
        bit   to;
        if (mode >= 0) load_table(mode);
        if (poke == 1) gold[0] = ~fut(N'(0));
        sb_q.push_back(model_expect(int'(NV) * 2));
        run_sweep(poke, got, to);
        exp = sb_q.pop_front();
        if (to) begin
            $display("FAIL %s.timeout got no done in %0d cycles want done", nm, got.cycles);
            n_bad++;
        end
        n_cmp++;
        if (got.err !== exp.err) begin
            $display("FAIL %s.err_count got %0d want %0d", nm, got.err, exp.err); n_bad++;
        end
        n_cmp++;
        if (got.first !== exp.first) begin
            $display("FAIL %s.first_err_addr got %0d want %0d", nm, got.first, exp.first); n_bad++;
        end
        n_cmp++;
        if (got.pass !== exp.pass) begin
            $display("FAIL %s.pass got %b want %b", nm, got.pass, exp.pass); n_bad++;
        end
        n_cmp++;
        if (got.cycles !== exp.cycles) begin
            $display("FAIL %s.latency got %0d want %0d", nm, got.cycles, exp.cycles); n_bad++;
        end
        n_cmp++;
        if (got.vec_bad !== exp.vec_bad) begin
            $display("FAIL %s.vec_seq got %0d bad samples want %0d", nm, got.vec_bad, exp.vec_bad); n_bad++;
        end
        n_cmp++;
        if ({got.done_after, got.busy_after} !== {exp.done_after, exp.busy_after}) begin
            $display("FAIL %s.after_done got done=%b busy=%b want 0 0", nm, got.done_after, got.busy_after);
            n_bad++;
        end
        n_cmp++;
        if (got.err0 !== exp.err0) begin
            $display("FAIL %s.start_clear got err=%0d want %0d", nm, got.err0, exp.err0); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_hold_after_done(input logic [EW-1:0] e, input logic p);
        repeat (20) @(posedge clk);
        #1;
        if ({err1, pass1} !== {e, p}) begin
            $display("FAIL hold.results got err=%0d pass=%b want err=%0d pass=%b", err1, pass1, e, p);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_sweep();
        int seen;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        if ({busy1, err1} !== {1'b1, EW'(1)}) begin
            $display("FAIL rstmid.before got busy=%b err=%0d want busy=1 err=1", busy1, err1); n_bad++;
        end
        n_cmp++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if ({busy1, done1, pass1, err1, first1, vec1} !== '0) begin
            $display("FAIL rstmid.after got busy=%b done=%b pass=%b err=%0d first=%0d vec=%0d want all 0",
                     busy1, done1, pass1, err1, first1, vec1);
            n_bad++;
        end
        n_cmp++;
        seen = 0;
        repeat (3200) begin
            @(posedge clk); #1;
            if (done1 || busy1) seen++;
        end
        if (seen !== 0) begin
            $display("FAIL rstmid.no_done got %0d active cycles want 0", seen); n_bad++;
        end
        n_cmp++;
        test_sweep("rstmid_rerun", -1, 0);
    endtask

    task automatic test_settle3();
        res_t exp;
        int   cnt, vbad;
        bit   to;
        load_table(0);
        sb_q.push_back(model_expect(int'(NV) * 4));
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cnt = 0; vbad = 0; to = 1'b1;
        if (vec3 !== '0) vbad++;
        while (cnt < 12000) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt < int'(NV) * 4 && vec3 !== N'(cnt >> 2)) vbad++;
            if (done3) begin
                to = 1'b0;
                break;
            end
        end
        exp = sb_q.pop_front();
        if (to || cnt !== exp.cycles) begin
            $display("FAIL settle3.latency got %0d want %0d", cnt, exp.cycles); n_bad++;
        end
        n_cmp++;
        if (vbad !== 0) begin
            $display("FAIL settle3.vec_hold got %0d bad samples want 0", vbad); n_bad++;
        end
        n_cmp++;
        if ({err3, first3, pass3} !== {exp.err, exp.first, exp.pass}) begin
            $display("FAIL settle3.result got err=%0d first=%0d pass=%b want err=%0d first=%0d pass=%b",
                     err3, first3, pass3, exp.err, exp.first, exp.pass);
            n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_sweep("clean", 0, 0);
        test_hold_after_done(EW'(0), 1'b1);
        test_sweep("flip2", 1, 0);
        test_reset_mid_sweep();
        test_sweep("ones", 2, 0);
        test_hold_after_done(model_expect(0).err, 1'b0);
        test_sweep("start_with_write", 0, 1);
        test_sweep("back_to_back", 0, 2);
        test_settle3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
